// File: rtl/gpu_mem_arbiter.sv
// gpu_mem_arbiter
// Two-port arbiter in front of a single memory channel. Port a is the GPU draw
// engine and port b is the display scanout prefetch. Commands pass through
// combinationally to the memory side. A small owner FIFO remembers which port
// issued each outstanding read, so that returning beats reach the right requester.
// A starvation counter makes sure port b gets a turn when port a keeps it waiting.

module gpu_mem_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,

    input  logic         a_command_i,
    input  logic [1:0]   a_size_i,
    input  logic         a_write_i,
    input  logic [14:0]  a_adr_i,
    input  logic [2:0]   a_subadr_i,
    input  logic [15:0]  a_mask_i,
    input  logic [255:0] a_data_i,
    output logic         a_busy_o,
    output logic         a_data_valid_o,

    input  logic         b_command_i,
    input  logic [1:0]   b_size_i,
    input  logic         b_write_i,
    input  logic [14:0]  b_adr_i,
    input  logic [2:0]   b_subadr_i,
    input  logic [15:0]  b_mask_i,
    input  logic [255:0] b_data_i,
    output logic         b_busy_o,
    output logic         b_data_valid_o,

    output logic [255:0] data_o,

    output logic         mem_command_o,
    output logic [1:0]   mem_size_o,
    output logic         mem_write_o,
    output logic [14:0]  mem_adr_o,
    output logic [2:0]   mem_subadr_o,
    output logic [15:0]  mem_mask_o,
    output logic [255:0] mem_data_o,
    input  logic         mem_busy_i,
    input  logic         mem_data_valid_i,
    input  logic [255:0] mem_data_i,

    output logic         err_o
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {
        A_PRIO = 1'b0,
        B_PRIO = 1'b1
    } prio_t;

    prio_t              state_q;
    prio_t              state_d;
    logic [CNT_W-1:0]   starve_q;
    logic [CNT_W-1:0]   starve_d;
    logic [CNT_W-1:0]   starve_inc;

    logic [FIFO_DEPTH-1:0] owner_q;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [PTR_W:0]        count_q;
    logic                  err_q;

    logic a_wins;
    logic b_wins;
    logic fifo_full;
    logic fifo_empty;
    logic a_grant;
    logic b_grant;
    logic push;
    logic push_id;
    logic pop;
    logic pop_id;
    logic bad_beat;

    // Pick the arbitration winner from the current requests and priority state.
    always_comb begin
        a_wins = 1'b0;
        b_wins = 1'b0;
        if (state_q == A_PRIO) begin
            a_wins = a_command_i;
            b_wins = b_command_i & ~a_command_i;
        end else begin
            b_wins = b_command_i;
            a_wins = a_command_i & ~b_command_i;
        end
    end

    // Busy, grant and FIFO handshake terms; a full FIFO blocks reads even if a beat pops this cycle.
    always_comb begin
        fifo_full  = (count_q == DEPTH_C);
        fifo_empty = (count_q == '0);

        a_busy_o = rst_i | mem_busy_i | ~a_wins | (~a_write_i & fifo_full);
        b_busy_o = rst_i | mem_busy_i | ~b_wins | (~b_write_i & fifo_full);

        a_grant = a_command_i & ~a_busy_o;
        b_grant = b_command_i & ~b_busy_o;

        push    = (a_grant & ~a_write_i) | (b_grant & ~b_write_i);
        push_id = b_grant;

        pop      = mem_data_valid_i & ~fifo_empty & ~rst_i;
        pop_id   = owner_q[rd_ptr_q];
        bad_beat = mem_data_valid_i & fifo_empty;
    end

    // Route the granted port's command fields to memory; port a's fields are the idle default.
    always_comb begin
        mem_command_o = a_grant | b_grant;
        mem_size_o    = a_size_i;
        mem_write_o   = a_write_i;
        mem_adr_o     = a_adr_i;
        mem_subadr_o  = a_subadr_i;
        mem_mask_o    = a_mask_i;
        mem_data_o    = a_data_i;
        if (b_grant) begin
            mem_size_o   = b_size_i;
            mem_write_o  = b_write_i;
            mem_adr_o    = b_adr_i;
            mem_subadr_o = b_subadr_i;
            mem_mask_o   = b_mask_i;
            mem_data_o   = b_data_i;
        end
    end

    // Steer each returning beat to the port that issued the oldest outstanding read.
    always_comb begin
        data_o         = mem_data_i;
        a_data_valid_o = pop & ~pop_id;
        b_data_valid_o = pop &  pop_id;
        err_o          = err_q;
    end

    // Priority FSM next state and starvation counter; everything is frozen while memory is busy.
    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        starve_inc = starve_q + CNT_W'(1);
        if (!mem_busy_i) begin
            case (state_q)
                A_PRIO: begin
                    if (!b_command_i || b_grant) begin
                        starve_d = '0;
                    end else if (a_grant) begin
                        if (starve_inc == LIMIT_C) begin
                            state_d  = B_PRIO;
                            starve_d = '0;
                        end else begin
                            starve_d = starve_inc;
                        end
                    end
                end
                B_PRIO: begin
                    if (b_grant) begin
                        state_d  = A_PRIO;
                        starve_d = '0;
                    end else if (!b_command_i) begin
                        starve_d = '0;
                    end
                end
                default: begin
                    state_d  = A_PRIO;
                    starve_d = '0;
                end
            endcase
        end
    end

    // Priority state and starvation counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= A_PRIO;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Owner FIFO: push on accepted reads, pop on each returned beat; simultaneous push and pop keep the count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                owner_q[wr_ptr_q] <= push_id;
                wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky error flag for a beat that arrives with no read outstanding.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (bad_beat) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// tb_gpu_mem_arbiter
// Directed bench for gpu_mem_arbiter. The stimulus pushes expected grants and
// read returns into queues, and a monitor pops them whenever the DUT shows
// mem_command_o or a data valid. Busy and error flags are also checked directly.

module tb_gpu_mem_arbiter;

    logic         clk_i;
    logic         rst_i;
    logic         a_command_i, b_command_i;
    logic [1:0]   a_size_i, b_size_i;
    logic         a_write_i, b_write_i;
    logic [14:0]  a_adr_i, b_adr_i;
    logic [2:0]   a_subadr_i, b_subadr_i;
    logic [15:0]  a_mask_i, b_mask_i;
    logic [255:0] a_data_i, b_data_i;
    logic         a_busy_o, b_busy_o;
    logic         a_data_valid_o, b_data_valid_o;
    logic [255:0] data_o;
    logic         mem_command_o;
    logic [1:0]   mem_size_o;
    logic         mem_write_o;
    logic [14:0]  mem_adr_o;
    logic [2:0]   mem_subadr_o;
    logic [15:0]  mem_mask_o;
    logic [255:0] mem_data_o;
    logic         mem_busy_i;
    logic         mem_data_valid_i;
    logic [255:0] mem_data_i;
    logic         err_o;

    typedef struct packed {
        logic [14:0]  adr;
        logic         wr;
        logic [1:0]   size;
        logic [15:0]  mask;
        logic [255:0] data;
    } grant_t;

    typedef struct packed {
        logic         owner;
        logic [255:0] data;
    } ret_t;

    grant_t       grantQ[$];
    ret_t         retQ[$];
    logic [255:0] memQ[$];
    grant_t       monGrant;
    ret_t         monRet;

    int checks = 0;
    int passes = 0;

    gpu_mem_arbiter #(.STARVE_LIMIT(8), .FIFO_DEPTH(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .a_command_i(a_command_i), .a_size_i(a_size_i), .a_write_i(a_write_i),
        .a_adr_i(a_adr_i), .a_subadr_i(a_subadr_i), .a_mask_i(a_mask_i),
        .a_data_i(a_data_i), .a_busy_o(a_busy_o), .a_data_valid_o(a_data_valid_o),
        .b_command_i(b_command_i), .b_size_i(b_size_i), .b_write_i(b_write_i),
        .b_adr_i(b_adr_i), .b_subadr_i(b_subadr_i), .b_mask_i(b_mask_i),
        .b_data_i(b_data_i), .b_busy_o(b_busy_o), .b_data_valid_o(b_data_valid_o),
        .data_o(data_o),
        .mem_command_o(mem_command_o), .mem_size_o(mem_size_o), .mem_write_o(mem_write_o),
        .mem_adr_o(mem_adr_o), .mem_subadr_o(mem_subadr_o), .mem_mask_o(mem_mask_o),
        .mem_data_o(mem_data_o), .mem_busy_i(mem_busy_i),
        .mem_data_valid_i(mem_data_valid_i), .mem_data_i(mem_data_i),
        .err_o(err_o)
    );

    // Free-running clock.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [255:0] token(input logic [14:0] adr);
        logic [31:0] word;
        word = {17'd0, adr};
        return {8{word}};
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic ac, input logic aw, input logic [14:0] aadr,
                                 input logic bc, input logic bw, input logic [14:0] badr,
                                 input logic mbusy, input logic mval);
        a_command_i = ac;  a_write_i = aw;  a_adr_i = aadr;
        a_size_i = 2'd1;   a_subadr_i = 3'd1; a_mask_i = 16'hAAAA; a_data_i = token(aadr);
        b_command_i = bc;  b_write_i = bw;  b_adr_i = badr;
        b_size_i = 2'd2;   b_subadr_i = 3'd2; b_mask_i = 16'h5555; b_data_i = token(badr);
        mem_busy_i = mbusy;
        mem_data_valid_i = mval;
        mem_data_i = 256'hDEAD;
        if (mval && memQ.size() > 0) mem_data_i = memQ.pop_front();
    endtask

    task automatic expectGrant(input logic [14:0] adr, input logic wr, input logic isB);
        grant_t g;
        g.adr  = adr;
        g.wr   = wr;
        g.size = isB ? 2'd2 : 2'd1;
        g.mask = isB ? 16'h5555 : 16'hAAAA;
        g.data = token(adr);
        grantQ.push_back(g);
    endtask

    task automatic expectRead(input logic isB, input logic [14:0] adr);
        ret_t r;
        expectGrant(adr, 1'b0, isB);
        r.owner = isB;
        r.data  = token(adr);
        retQ.push_back(r);
        memQ.push_back(token(adr));
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 15'h0, 1'b0, 1'b0, 15'h0, 1'b0, 1'b0);
    endtask

    task automatic mid();
        @(negedge clk_i);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: compare every memory command and every read return against the queues.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (mem_command_o) begin
                if (grantQ.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected_grant: actual adr=%0h expected no grant", mem_adr_o);
                end else begin
                    monGrant = grantQ.pop_front();
                    checkOutput("grant_adr", mem_adr_o, monGrant.adr);
                    checkOutput("grant_write", mem_write_o, monGrant.wr);
                    checkOutput("grant_size", mem_size_o, monGrant.size);
                    checkOutput("grant_mask", mem_mask_o, monGrant.mask);
                    checkOutput("grant_data", mem_data_o, monGrant.data);
                end
            end
            if (a_data_valid_o || b_data_valid_o) begin
                if (retQ.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected_return: actual a=%0b b=%0b expected none",
                             a_data_valid_o, b_data_valid_o);
                end else begin
                    monRet = retQ.pop_front();
                    checkOutput("ret_owner_b", b_data_valid_o, monRet.owner);
                    checkOutput("ret_owner_a", a_data_valid_o, !monRet.owner);
                    checkOutput("ret_data", data_o, monRet.data);
                end
            end
        end
    end

    // Directed scenarios.
    initial begin
        logic expOwner[4];
        logic [14:0] ra[4];

        rst_i = 1'b1;
        applyStimulus(1'b1, 1'b0, 15'h0011, 1'b1, 1'b0, 15'h0022, 1'b0, 1'b1);
        mid();
        checkOutput("reset_a_busy", a_busy_o, 1'b1);
        checkOutput("reset_b_busy", b_busy_o, 1'b1);
        checkOutput("reset_mem_command", mem_command_o, 1'b0);
        checkOutput("reset_a_valid", a_data_valid_o, 1'b0);
        checkOutput("reset_b_valid", b_data_valid_o, 1'b0);
        checkOutput("reset_err", err_o, 1'b0);
        tick();
        idle();
        rst_i = 1'b0;
        tick();

        // Both ports read: a wins, then a's beat returns to a.
        $display("[TB] both ports read");
        applyStimulus(1'b1, 1'b0, 15'h0011, 1'b1, 1'b0, 15'h0022, 1'b0, 1'b0);
        expectRead(1'b0, 15'h0011);
        mid();
        checkOutput("s1_a_busy", a_busy_o, 1'b0);
        checkOutput("s1_b_busy", b_busy_o, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 15'h0, 1'b0, 1'b0, 15'h0, 1'b0, 1'b1);
        mid();
        checkOutput("s1_a_valid", a_data_valid_o, 1'b1);
        checkOutput("s1_b_valid", b_data_valid_o, 1'b0);
        tick();

        // Continuous requests with a 5-cycle memory stall after 4 a-grants.
        $display("[TB] starvation with stall");
        for (int i = 0; i < 13; i++) begin
            if (i >= 4 && i < 9) begin
                applyStimulus(1'b1, 1'b1, 15'h0100, 1'b1, 1'b1, 15'h0200, 1'b1, 1'b0);
                mid();
                checkOutput("stall_a_busy", a_busy_o, 1'b1);
                checkOutput("stall_b_busy", b_busy_o, 1'b1);
                checkOutput("stall_mem_command", mem_command_o, 1'b0);
            end else begin
                applyStimulus(1'b1, 1'b1, 15'h0100, 1'b1, 1'b1, 15'h0200, 1'b0, 1'b0);
                expectGrant(15'h0100, 1'b1, 1'b0);
                mid();
                checkOutput("starve_a_busy", a_busy_o, 1'b0);
                checkOutput("starve_b_busy", b_busy_o, 1'b1);
            end
            tick();
        end
        applyStimulus(1'b1, 1'b1, 15'h0100, 1'b1, 1'b1, 15'h0200, 1'b0, 1'b0);
        expectGrant(15'h0200, 1'b1, 1'b1);
        mid();
        checkOutput("starve_b_turn_b_busy", b_busy_o, 1'b0);
        checkOutput("starve_b_turn_a_busy", a_busy_o, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b1, 15'h0100, 1'b1, 1'b1, 15'h0200, 1'b0, 1'b0);
        expectGrant(15'h0100, 1'b1, 1'b0);
        mid();
        checkOutput("starve_back_a_busy", a_busy_o, 1'b0);
        checkOutput("starve_back_b_busy", b_busy_o, 1'b1);
        tick();
        idle();
        tick();

        // Four reads b,a,b,a fill the FIFO; more reads refused, writes still accepted.
        $display("[TB] fifo full");
        expOwner = '{1'b1, 1'b0, 1'b1, 1'b0};
        ra = '{15'h0031, 15'h0032, 15'h0033, 15'h0034};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(!expOwner[i], 1'b0, ra[i], expOwner[i], 1'b0, ra[i], 1'b0, 1'b0);
            expectRead(expOwner[i], ra[i]);
            mid();
            checkOutput("fill_busy", expOwner[i] ? b_busy_o : a_busy_o, 1'b0);
            tick();
        end
        applyStimulus(1'b1, 1'b0, 15'h0035, 1'b0, 1'b0, 15'h0, 1'b0, 1'b0);
        mid();
        checkOutput("full_a_read_busy", a_busy_o, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 15'h0, 1'b1, 1'b0, 15'h0036, 1'b0, 1'b0);
        mid();
        checkOutput("full_b_read_busy", b_busy_o, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b1, 15'h0037, 1'b0, 1'b0, 15'h0, 1'b0, 1'b0);
        expectGrant(15'h0037, 1'b1, 1'b0);
        mid();
        checkOutput("full_a_write_busy", a_busy_o, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 15'h0, 1'b1, 1'b1, 15'h0038, 1'b0, 1'b0);
        expectGrant(15'h0038, 1'b1, 1'b1);
        mid();
        checkOutput("full_b_write_busy", b_busy_o, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 15'h0, 1'b0, 1'b0, 15'h0, 1'b0, 1'b1);
            mid();
            checkOutput("drain_b_valid", b_data_valid_o, expOwner[i]);
            tick();
        end
        idle();
        mid();
        checkOutput("drain_err", err_o, 1'b0);
        tick();

        // Push and pop in the same cycle at count 2.
        $display("[TB] simultaneous push and pop");
        applyStimulus(1'b1, 1'b0, 15'h0041, 1'b0, 1'b0, 15'h0, 1'b0, 1'b0);
        expectRead(1'b0, 15'h0041);
        tick();
        applyStimulus(1'b0, 1'b0, 15'h0, 1'b1, 1'b0, 15'h0042, 1'b0, 1'b0);
        expectRead(1'b1, 15'h0042);
        tick();
        applyStimulus(1'b1, 1'b0, 15'h0043, 1'b0, 1'b0, 15'h0, 1'b0, 1'b1);
        expectRead(1'b0, 15'h0043);
        mid();
        checkOutput("pp_a_busy", a_busy_o, 1'b0);
        checkOutput("pp_a_valid", a_data_valid_o, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 15'h0044, 1'b0, 1'b0, 15'h0, 1'b0, 1'b0);
        expectRead(1'b0, 15'h0044);
        mid();
        checkOutput("pp_fill3_busy", a_busy_o, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 15'h0, 1'b1, 1'b0, 15'h0045, 1'b0, 1'b0);
        expectRead(1'b1, 15'h0045);
        mid();
        checkOutput("pp_fill4_busy", b_busy_o, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 15'h0046, 1'b0, 1'b0, 15'h0, 1'b0, 1'b1);
        mid();
        checkOutput("full_pop_a_busy", a_busy_o, 1'b1);
        checkOutput("full_pop_b_valid", b_data_valid_o, 1'b1);
        tick();
        expOwner = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 15'h0, 1'b0, 1'b0, 15'h0, 1'b0, 1'b1);
            mid();
            checkOutput("pp_drain_b_valid", b_data_valid_o, expOwner[i]);
            tick();
        end

        // Beat with empty FIFO sets a sticky error, cleared only by reset.
        $display("[TB] empty-fifo beat");
        applyStimulus(1'b0, 1'b0, 15'h0, 1'b0, 1'b0, 15'h0, 1'b0, 1'b1);
        mid();
        checkOutput("err_beat_a_valid", a_data_valid_o, 1'b0);
        checkOutput("err_beat_b_valid", b_data_valid_o, 1'b0);
        tick();
        idle();
        mid();
        checkOutput("err_set", err_o, 1'b1);
        tick();
        tick();
        tick();
        mid();
        checkOutput("err_held", err_o, 1'b1);
        tick();
        rst_i = 1'b1;
        mid();
        checkOutput("err_cleared_in_reset", err_o, 1'b0);
        tick();
        rst_i = 1'b0;
        mid();
        checkOutput("err_cleared_after_reset", err_o, 1'b0);
        tick();

        // Reset while a read is outstanding discards its ownership.
        $display("[TB] reset with outstanding read");
        applyStimulus(1'b1, 1'b0, 15'h0051, 1'b0, 1'b0, 15'h0, 1'b0, 1'b0);
        expectGrant(15'h0051, 1'b0, 1'b0);
        tick();
        idle();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 15'h0, 1'b0, 1'b0, 15'h0, 1'b0, 1'b1);
        mid();
        checkOutput("post_reset_a_valid", a_data_valid_o, 1'b0);
        checkOutput("post_reset_b_valid", b_data_valid_o, 1'b0);
        tick();
        idle();
        mid();
        checkOutput("post_reset_err", err_o, 1'b1);
        tick();

        checkOutput("grant_queue_drained", grantQ.size(), 0);
        checkOutput("return_queue_drained", retQ.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
